mealy_seq_detector: RTL and testbench
=====================================

MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1101: PAT_W-bit target; PATTERN[PAT_W-1] is the first bit expected.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = detector restarts from empty after each match.
REQ-004 Parameter CNT_W, default 8: width of match counter.
REQ-005 Port clk  input  1  single clock, all state updates on rising edge.
REQ-006 Port rst  input  1  synchronous, active-low reset.
REQ-007 Port x  input  1  serial data bit.
REQ-008 Port xValid  input  1  qualifies x; bit consumed only when high.
REQ-009 Port cntClr  input  1  synchronous clear of matchCount.
REQ-010 Port y  output  2  y[1] = match (Mealy, combinational), y[0] = partial (stateReg != 0).
REQ-011 Port stateReg  output  SW = $clog2(PAT_W)  current prefix length matched, 0..PAT_W-1.
REQ-012 Port nextStateReg  output  SW  combinational next state.
REQ-013 Port matchCount  output  CNT_W  saturating match count (present only with MATCH_CNT_EN).

Function
REQ-014 State S = length of longest prefix of PATTERN that equals a suffix of consumed bits, excluding a full match; S in 0..PAT_W-1.
REQ-015 Transition tables SHALL derive at elaboration from PATTERN (KMP failure function); no hardcoded state encodings.
REQ-016 match = rst & xValid & (stateReg == PAT_W-1) & (x == PATTERN[0]); zero-latency, same cycle as final bit.
REQ-017 On consumed bit x from S with no match: nextStateReg = longest prefix of PATTERN that is a suffix of (prefix_S followed by x).
REQ-018 On match with OVERLAP=1: nextStateReg = length of longest proper border of PATTERN; with OVERLAP=0: nextStateReg = 0.
REQ-019 xValid low: nextStateReg = stateReg, match = 0; state holds indefinitely.
REQ-020 stateReg <= nextStateReg every rising edge when rst high.
REQ-021 y[0] reflects registered stateReg only, no combinational path from x.
REQ-022 matchCount increments by 1 on each rising edge where match = 1; saturates at 2^CNT_W-1, no wrap.
REQ-023 cntClr and match in same cycle: cntClr wins, matchCount = 0.
REQ-024 All-ones or all-zeros PATTERN SHALL be handled by same derivation (border = PAT_W-1).

Reset
REQ-025 rst low at rising edge: stateReg = 0, matchCount = 0 next cycle.
REQ-026 While rst low: match forced 0, nextStateReg = 0, y = 2'b00, regardless of x/xValid.
REQ-027 Reset mid-sequence discards partial progress; first post-reset bit evaluated from state 0.

Configuration
REQ-028 Macro MATCH_CNT_EN defined: matchCount port, counter and cntClr logic present per REQ-022/023.
REQ-029 MATCH_CNT_EN undefined: matchCount port and counter absent; cntClr port present but ignored; all other behaviour identical.

Verification
REQ-030 rst low 1 cycle, x=1 xValid=1 -> stateReg=0, y=00 during reset; stateReg=1 after first post-reset edge.
REQ-031 PAT_W=4, PATTERN=1101, OVERLAP=1, bits 1,1,0,1,1,0,1 -> y[1]=1 on bits 4 and 7 only; stateReg after bit 4 = 1; matchCount=2.
REQ-032 Same bits, OVERLAP=0 -> y[1]=1 on bit 4 only; stateReg after bit 4 = 0; matchCount=1.
REQ-033 Bits 1,1,0 then xValid=0 three cycles with x toggling, then 1 -> stateReg holds 3, y[1]=0 while invalid, y[1]=1 on final bit.
REQ-034 CNT_W=2, PATTERN=11, OVERLAP=1, ten consecutive 1s -> matchCount saturates at 3; cntClr with match -> matchCount=0.
REQ-035 Bits 1,1,0 then rst low one cycle, then 1 -> no match, stateReg=1.

Source files
------------

// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector: serial Mealy pattern detector with KMP-derived transitions.
// Optional match counter is built when MATCH_CNT_EN is defined.  Rev 1.0
`default_nettype none

module mealy_seq_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8,
  localparam int              SW      = $clog2(PAT_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x,
  input  logic          xValid,
  input  logic          cntClr,
  output logic [1:0]    y,
  output logic [SW-1:0] stateReg,
  output logic [SW-1:0] nextStateReg
`ifdef MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] matchCount
`endif
);

  // Longest prefix of PATTERN (shorter than PAT_W) that is a suffix of prefix_s followed by b.
  function automatic int next_fn(input int s, input logic b);
    int   res;
    int   pos;
    logic ok;
    logic sb;
    res = 0;
    for (int k = 1; k <= s + 1; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        pos = s + 1 - k + i;
        sb  = (pos < s) ? PATTERN[PAT_W-1-pos] : b;
        if (sb != PATTERN[PAT_W-1-i]) ok = 1'b0;
      end
      if (ok && (k < PAT_W)) res = k;
    end
    return res;
  endfunction

  function automatic int border_fn();
    int   res;
    logic ok;
    res = 0;
    for (int k = 1; k < PAT_W; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (PATTERN[PAT_W-1-i] != PATTERN[k-1-i]) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  localparam logic [SW-1:0] LAST_S   = SW'(PAT_W - 1);
  localparam logic [SW-1:0] BORDER_S = SW'((OVERLAP != 0) ? border_fn() : 0);

  logic [SW-1:0] nxt0_tbl [PAT_W];
  logic [SW-1:0] nxt1_tbl [PAT_W];
  logic          match;

  generate
    for (genvar gs = 0; gs < PAT_W; gs++) begin : g_tbl
      localparam int N0 = next_fn(gs, 1'b0);
      localparam int N1 = next_fn(gs, 1'b1);
      assign nxt0_tbl[gs] = SW'(N0);
      assign nxt1_tbl[gs] = SW'(N1);
    end
  endgenerate

  always_comb begin
    match        = 1'b0;
    nextStateReg = '0;
    if (rst) begin
      nextStateReg = stateReg;
      if (xValid) begin
        if ((stateReg == LAST_S) && (x == PATTERN[0])) begin
          match        = 1'b1;
          nextStateReg = BORDER_S;
        end else begin
          nextStateReg = x ? nxt1_tbl[stateReg] : nxt0_tbl[stateReg];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) stateReg <= '0;
    else      stateReg <= nextStateReg;
  end

  // Partial flag comes from the register only; rst gating keeps y quiet during reset.
  assign y = {match, rst & (stateReg != '0)};

`ifdef MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst || cntClr)                       matchCount <= '0;
    else if (match && (matchCount != CNT_MAX)) matchCount <= matchCount + 1'b1;
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cntClr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench: directed steps push hand-computed expectations, a negedge monitor pops and compares.
`default_nettype none

module tb_mealy_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Group A drives an OVERLAP=1 and an OVERLAP=0 instance of 1101; group B drives PATTERN=11, CNT_W=2.
  logic rst_a = 1'b0, x_a = 1'b0, xv_a = 1'b0;
  logic rst_b = 1'b0, x_b = 1'b0, xv_b = 1'b0, clr_b = 1'b0;
  logic [1:0] y_o1, y_o0, y_b;
  logic [1:0] st_o1, st_o0, nx_o1, nx_o0;
  logic [0:0] st_b, nx_b;
`ifdef MATCH_CNT_EN
  logic [7:0] cnt_o1, cnt_o0;
  logic [1:0] cnt_b;
`endif

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) dut_o1 (
    .clk(clk), .rst(rst_a), .x(x_a), .xValid(xv_a), .cntClr(1'b0),
    .y(y_o1), .stateReg(st_o1), .nextStateReg(nx_o1)
`ifdef MATCH_CNT_EN
    , .matchCount(cnt_o1)
`endif
  );

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) dut_o0 (
    .clk(clk), .rst(rst_a), .x(x_a), .xValid(xv_a), .cntClr(1'b0),
    .y(y_o0), .stateReg(st_o0), .nextStateReg(nx_o0)
`ifdef MATCH_CNT_EN
    , .matchCount(cnt_o0)
`endif
  );

  mealy_seq_detector #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .x(x_b), .xValid(xv_b), .cntClr(clr_b),
    .y(y_b), .stateReg(st_b), .nextStateReg(nx_b)
`ifdef MATCH_CNT_EN
    , .matchCount(cnt_b)
`endif
  );

  typedef struct {
    logic [1:0] y1, s1, n1;
    logic [1:0] y0, s0, n0;
  } exp_a_t;

  typedef struct {
    logic [1:0] y;
    logic       s, n;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      exp_a_t e;
      e = qa.pop_front();
      chk("ov1_y",     8'(y_o1),  8'(e.y1));
      chk("ov1_state", 8'(st_o1), 8'(e.s1));
      chk("ov1_next",  8'(nx_o1), 8'(e.n1));
      chk("ov0_y",     8'(y_o0),  8'(e.y0));
      chk("ov0_state", 8'(st_o0), 8'(e.s0));
      chk("ov0_next",  8'(nx_o0), 8'(e.n0));
    end
    if (qb.size() > 0) begin
      exp_b_t e;
      e = qb.pop_front();
      chk("p11_y",     8'(y_b),  8'(e.y));
      chk("p11_state", 8'(st_b), 8'(e.s));
      chk("p11_next",  8'(nx_b), 8'(e.n));
    end
  end

  task automatic step_a(input logic r, input logic v, input logic b,
                        input logic [1:0] y1, input logic [1:0] s1, input logic [1:0] n1,
                        input logic [1:0] y0, input logic [1:0] s0, input logic [1:0] n0);
    exp_a_t e;
    @(posedge clk); #1;
    rst_a = r; xv_a = v; x_a = b;
    e.y1 = y1; e.s1 = s1; e.n1 = n1;
    e.y0 = y0; e.s0 = s0; e.n0 = n0;
    qa.push_back(e);
  endtask

  task automatic step_b(input logic r, input logic v, input logic b, input logic c,
                        input logic [1:0] y, input logic s, input logic n);
    exp_b_t e;
    @(posedge clk); #1;
    rst_b = r; xv_b = v; x_b = b; clr_b = c;
    e.y = y; e.s = s; e.n = n;
    qb.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;

    // Reset with x=1 valid, first post-reset bit, then reset while partial to check y gating.
    step_a(0, 1, 1, 2'b00, 2'd0, 2'd0, 2'b00, 2'd0, 2'd0);
    step_a(1, 1, 1, 2'b00, 2'd0, 2'd1, 2'b00, 2'd0, 2'd1);
    step_a(0, 1, 0, 2'b00, 2'd1, 2'd0, 2'b00, 2'd1, 2'd0);

    // 1,1,0,1,1,0,1 : overlapping sees matches on bits 4 and 7, non-overlapping on bit 4 only.
    step_a(1, 1, 1, 2'b00, 2'd0, 2'd1, 2'b00, 2'd0, 2'd1);
    step_a(1, 1, 1, 2'b01, 2'd1, 2'd2, 2'b01, 2'd1, 2'd2);
    step_a(1, 1, 0, 2'b01, 2'd2, 2'd3, 2'b01, 2'd2, 2'd3);
    step_a(1, 1, 1, 2'b11, 2'd3, 2'd1, 2'b11, 2'd3, 2'd0);
    step_a(1, 1, 1, 2'b01, 2'd1, 2'd2, 2'b00, 2'd0, 2'd1);
    step_a(1, 1, 0, 2'b01, 2'd2, 2'd3, 2'b01, 2'd1, 2'd0);
    step_a(1, 1, 1, 2'b11, 2'd3, 2'd1, 2'b00, 2'd0, 2'd1);

    // Reset, then 1,1,0, three invalid cycles with x toggling, then the final 1.
    step_a(0, 1, 1, 2'b00, 2'd1, 2'd0, 2'b00, 2'd1, 2'd0);
`ifdef MATCH_CNT_EN
    @(negedge clk);
    chk("ov1_count", cnt_o1, 8'd2);
    chk("ov0_count", cnt_o0, 8'd1);
`endif
    step_a(1, 1, 1, 2'b00, 2'd0, 2'd1, 2'b00, 2'd0, 2'd1);
    step_a(1, 1, 1, 2'b01, 2'd1, 2'd2, 2'b01, 2'd1, 2'd2);
    step_a(1, 1, 0, 2'b01, 2'd2, 2'd3, 2'b01, 2'd2, 2'd3);
    step_a(1, 0, 1, 2'b01, 2'd3, 2'd3, 2'b01, 2'd3, 2'd3);
    step_a(1, 0, 0, 2'b01, 2'd3, 2'd3, 2'b01, 2'd3, 2'd3);
    step_a(1, 0, 1, 2'b01, 2'd3, 2'd3, 2'b01, 2'd3, 2'd3);
    step_a(1, 1, 1, 2'b11, 2'd3, 2'd1, 2'b11, 2'd3, 2'd0);

    // 1,1,0 then reset one cycle, then 1: no match, state ends at 1.
    step_a(1, 1, 1, 2'b01, 2'd1, 2'd2, 2'b00, 2'd0, 2'd1);
    step_a(1, 1, 1, 2'b01, 2'd2, 2'd2, 2'b01, 2'd1, 2'd2);
    step_a(1, 1, 0, 2'b01, 2'd2, 2'd3, 2'b01, 2'd2, 2'd3);
    step_a(0, 1, 1, 2'b00, 2'd3, 2'd0, 2'b00, 2'd3, 2'd0);
    step_a(1, 1, 1, 2'b00, 2'd0, 2'd1, 2'b00, 2'd0, 2'd1);
    step_a(1, 0, 0, 2'b01, 2'd1, 2'd1, 2'b01, 2'd1, 2'd1);
    @(posedge clk); #1 xv_a = 1'b0;

    // Pattern 11: ten consecutive ones, counter saturates; then clear coinciding with a match.
    step_b(1, 1, 1, 0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step_b(1, 1, 1, 0, 2'b11, 1'b1, 1'b1);
    step_b(1, 1, 1, 1, 2'b11, 1'b1, 1'b1);
`ifdef MATCH_CNT_EN
    @(negedge clk);
    chk("p11_count_sat", 8'(cnt_b), 8'd3);
`endif
    step_b(1, 1, 0, 0, 2'b01, 1'b1, 1'b0);
`ifdef MATCH_CNT_EN
    @(negedge clk);
    chk("p11_count_clr", 8'(cnt_b), 8'd0);
`endif
    step_b(1, 1, 0, 0, 2'b00, 1'b0, 1'b0);
    @(posedge clk); #1 xv_b = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_drain", 8'(qa.size() + qb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
